axis_frame_reframer: RTL and testbench
======================================

// Module: axis_frame_reframer
// PURPOSE
//  Downstream stage of barrel_distortion_correction. Takes its AXI-Stream output (tuser = start of frame, tlast = end of frame).
//  Re-emits an exactly WIDTH x HEIGHT frame with tuser on the first pixel and tlast on every end of line, for the video output / DMA.
//  Short frames are padded, long frames truncated, and both are flagged. An internal FIFO absorbs sink backpressure.
// PARAMETERS
//  WIDTH       128       active pixels per line
//  HEIGHT      100       lines per frame
//  DATA_WIDTH  24        pixel width (RGB888)
//  FIFO_DEPTH  16        output FIFO entries; power of 2, >=2
//  PAD_VALUE   24'h0     pixel value used to fill short frames
// PORTS
//  clk            in   1           single clock, all logic on rising edge
//  rst_n          in   1           synchronous, active-low reset
//  s_axis_tdata   in   DATA_WIDTH  input pixel
//  s_axis_tvalid  in   1           input beat valid
//  s_axis_tlast   in   1           input end of frame
//  s_axis_tuser   in   1           input start of frame
//  s_axis_tready  out  1           input beat accepted when tvalid&&tready
//  m_axis_tdata   out  DATA_WIDTH  output pixel
//  m_axis_tvalid  out  1           output beat valid
//  m_axis_tlast   out  1           output end of line (x==WIDTH-1)
//  m_axis_tuser   out  1           output start of frame (x==0,y==0)
//  m_axis_tready  in   1           sink ready
//  frame_done     out  1           1-cycle pulse when the last pixel of a frame is written to the FIFO
//  err_short      out  1           1-cycle pulse: input tlast before WIDTH*HEIGHT pixels
//  err_long       out  1           1-cycle pulse: WIDTH*HEIGHT pixels received without tlast
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, x/y counters 0; all outputs 0 while rst_n=0.
//   A reset mid-frame flushes the FIFO and drops the partial frame.
//  FIFO word = {tuser,tlast,tdata}. Output side: m_axis_tvalid = !empty; fields come from the FIFO head and stay stable while stalled.
//   A beat pops on m_axis_tvalid&&m_axis_tready.
//  Push and pop in the same cycle leave the occupancy unchanged.
//   s_axis_tready depends only on !full and state, never combinationally on m_axis_tready.
//  Latency: a beat accepted at edge N is visible on m_axis at edge N+1 if the FIFO was empty.
//  x/y counters: x wraps at WIDTH-1 to 0 and then increments y.
//   Written tuser = (x==0&&y==0); written tlast = (x==WIDTH-1).
//  States (input/write side):
//   IDLE:   tready=!full. Beats with tuser=0 are discarded.
//           A tuser=1 beat is written at x=y=0 -> ACTIVE.
//           If that beat also has tlast=1 (and WIDTH*HEIGHT>1): err_short, -> PAD.
//   ACTIVE: tready=!full; every accepted beat is written. tuser on a non-first beat is ignored (treated as data).
//           Last pixel with tlast=1 -> frame_done, -> IDLE.
//           Last pixel with tlast=0 -> frame_done + err_long, -> DROP.
//           tlast on an earlier pixel -> write it, err_short, -> PAD.
//   PAD:    tready=0. Write PAD_VALUE on each cycle with !full until the last pixel is written.
//           Then frame_done, -> IDLE.
//   DROP:   tready=1. Discard beats until a beat with tlast=1 is accepted, -> IDLE.
//           A tuser=1 beat in DROP is also discarded.
//  The last pixel is written even if the sink stalls; the FIFO-full stall applies equally to the PAD and ACTIVE writes.
// CONFIGURATION
//  FRAME_STATS_EN defined:
//   Adds output ports frame_count[15:0], short_count[15:0], long_count[15:0].
//   These increment on frame_done, err_short and err_long respectively, wrap at 16'hFFFF->0, and clear on reset.
//  FRAME_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1) 128x100 ramp frame (tdata=i), tready=1:
//     -> 12800 out beats with tdata=i, tuser only on beat 0, tlast on beats 127,255,...,12799; one frame_done; no errors.
//  2) Same frame, m_axis_tready toggling 1-of-3 cycles:
//     -> identical output sequence; no beat lost or duplicated; tdata held stable while stalled.
//  3) Frame with tlast on pixel 5000:
//     -> err_short pulse; output beats 5001..12799 = PAD_VALUE; 12800 beats total; tlast on every line end.
//  4) Frame of 12810 pixels, tlast on the last one:
//     -> err_long when beat 12799 is written; 10 extra beats dropped; next SOF frame is output normally.
//  5) Pixels with tuser=0 before SOF: 7 beats discarded in IDLE; the frame then starts at the tuser beat.
//  6) rst_n=0 for 1 cycle at pixel 3000:
//     -> m_axis_tvalid=0 the following cycle; the next full frame is output correctly from beat 0.
//     With FRAME_STATS_EN, counters read 0 after the reset.

Source files
------------

// File: rtl/axis_frame_reframer.sv
// axis_frame_reframer: re-emits exactly WIDTH x HEIGHT AXI-Stream frames (pad short, truncate long) through an output FIFO.
// Optional FRAME_STATS_EN adds frame/short/long event counters.
module axis_frame_reframer #(
    parameter int WIDTH = 128,
    parameter int HEIGHT = 100,
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  frame_done,
    output logic                  err_short,
`ifdef FRAME_STATS_EN
    output logic [15:0]           frame_count,
    output logic [15:0]           short_count,
    output logic [15:0]           long_count,
`endif
    output logic                  err_long
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DROP} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full, push, pop, acc, at_eol, at_sof, last_pix;

    assign full          = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign at_eol        = x_q == XW'(WIDTH - 1);
    assign at_sof        = x_q == '0 && y_q == '0;
    assign last_pix      = at_eol && y_q == YW'(HEIGHT - 1);
    assign s_axis_tready = rst_n && (state_q == DROP || (state_q != PAD && !full));
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = rst_n && cnt_q != '0;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem_q[rp_q] : '0;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        push       = 1'b0;
        wr_data    = s_axis_tdata;
        frame_done = 1'b0;
        err_short  = 1'b0;
        err_long   = 1'b0;
        if (acc && (state_q == ACTIVE || (state_q == IDLE && s_axis_tuser))) begin
            push = 1'b1;
            if (last_pix) begin
                frame_done = 1'b1;
                err_long   = !s_axis_tlast;
                state_d    = s_axis_tlast ? IDLE : DROP;
            end else begin
                err_short = s_axis_tlast;
                state_d   = s_axis_tlast ? PAD : ACTIVE;
            end
        end else if (state_q == PAD && rst_n && !full) begin
            push    = 1'b1;
            wr_data = PAD_VALUE;
            if (last_pix) begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
        end else if (state_q == DROP && acc && s_axis_tlast) begin
            state_d = IDLE;
        end
        if (push) begin
            x_d = at_eol ? '0 : x_q + 1'b1;
            y_d = at_eol ? (last_pix ? '0 : y_q + 1'b1) : y_q;
        end
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        wp_d  = wp_q + AW'(push);
        rp_d  = rp_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    // FIFO word tags come from the write-side position, not from the input beat
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {at_sof, at_eol, wr_data};
    end

`ifdef FRAME_STATS_EN
    logic [15:0] frame_count_q, frame_count_d, short_count_q, short_count_d, long_count_q, long_count_d;

    always_comb begin
        frame_count_d = frame_count_q + 16'(frame_done);
        short_count_d = short_count_q + 16'(err_short);
        long_count_d  = long_count_q + 16'(err_long);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count_q <= '0;
            short_count_q <= '0;
            long_count_q  <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            short_count_q <= short_count_d;
            long_count_q  <= long_count_d;
        end
    end

    assign frame_count = rst_n ? frame_count_q : '0;
    assign short_count = rst_n ? short_count_q : '0;
    assign long_count  = rst_n ? long_count_q : '0;
`endif
endmodule

// File: tb/tb_axis_frame_reframer.sv
// tb_axis_frame_reframer: directed frames against a frame-level reference model with a per-beat compare process.
module tb_axis_frame_reframer;
    localparam int W = 8, H = 4, N = W * H, DW = 24, DEPTH = 4;
    localparam logic [DW-1:0] PAD = 24'hABCDEF;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
    logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0, s_axis_tready;
    logic m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready = 1'b1;
    logic frame_done, err_short, err_long;
`ifdef FRAME_STATS_EN
    logic [15:0] frame_count, short_count, long_count;
`endif

    always #5 clk = ~clk;

    axis_frame_reframer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PAD_VALUE(PAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .frame_done(frame_done), .err_short(err_short),
`ifdef FRAME_STATS_EN
        .frame_count(frame_count), .short_count(short_count), .long_count(long_count),
`endif
        .err_long(err_long)
    );

    typedef struct packed {logic user; logic last; logic [DW-1:0] data;} beat_t;

    beat_t stim[$], exp_q[$];
    int n_cmp = 0, n_err = 0, n_fd = 0, n_sh = 0, n_lg = 0, cyc = 0, rmode = 0;
    int fd0, sh0, lg0;
    bit chk_lat = 0, prev_stall = 0;
    logic [DW+2:0] prev;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic add_frame(input int pre, input int len, input int last_at, input int base);
        for (int i = 0; i < pre; i++) stim.push_back('{1'b0, 1'b0, DW'(24'h00DE00 + i)});
        for (int i = 0; i < len; i++) stim.push_back('{i == 0, i == last_at, DW'(base + i)});
    endtask

    // Frame-level reference: skip to SOF, take pixels up to tlast, pad or truncate to N.
    task automatic model();
        int pos, s, t, n;
        pos = 0;
        while (pos < stim.size()) begin
            s = pos;
            while (s < stim.size() && !stim[s].user) s++;
            if (s >= stim.size()) break;
            t = s;
            while (t < stim.size() - 1 && !stim[t].last) t++;
            n = t - s + 1;
            for (int i = 0; i < N; i++)
                exp_q.push_back('{i == 0, (i % W) == W - 1, i < n ? stim[s + i].data : PAD});
            pos = t + 1;
        end
    endtask

    task automatic send(input int cnt);
        int k;
        @(posedge clk);
        #1;
        for (int i = 0; i < cnt; i++) begin
            {s_axis_tuser, s_axis_tlast, s_axis_tdata} = stim[i];
            s_axis_tvalid = 1'b1;
            for (k = 0; k < 500; k++) begin
                @(negedge clk);
                if (s_axis_tready) break;
            end
            if (k == 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout beat=%0d got=tready0 want=tready1", i);
            end
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b0;
            if (chk_lat && i == 0) begin
                @(negedge clk);
                check("latency", {m_axis_tvalid, m_axis_tdata}, {1'b1, stim[0].data});
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (exp_q.size() != 0 || m_axis_tvalid); k++) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic run(input int fd, input int sh, input int lg);
        fd0 = n_fd;
        sh0 = n_sh;
        lg0 = n_lg;
        send(stim.size());
        drain();
        check("frame_done_cnt", n_fd - fd0, fd);
        check("err_short_cnt", n_sh - sh0, sh);
        check("err_long_cnt", n_lg - lg0, lg);
        stim.delete();
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        m_axis_tready = rmode != 0 ? (cyc % 3 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall)
                check("stall_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat got=%0h want=none", {m_axis_tuser, m_axis_tlast, m_axis_tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, e);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
            n_fd += int'(frame_done);
            n_sh += int'(err_short);
            n_lg += int'(err_long);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {m_axis_tvalid, m_axis_tdata, s_axis_tready, frame_done, err_short, err_long}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tready", s_axis_tready, 1);
        check("idle_tvalid", m_axis_tvalid, 0);

        add_frame(0, N, N - 1, 0);
        model();
        check("model_t1_size", exp_q.size(), N);
        check("model_t1_last", exp_q[N-1], {1'b0, 1'b1, DW'(N - 1)});
        chk_lat = 1;
        run(1, 0, 0);
        chk_lat = 0;

        rmode = 1;
        add_frame(0, N, N - 1, 0);
        model();
        run(1, 0, 0);
        rmode = 0;

        add_frame(0, 6, 5, 500);
        model();
        check("model_t3_px5", exp_q[5], {1'b0, 1'b0, DW'(505)});
        check("model_t3_pad", exp_q[6], {1'b0, 1'b0, PAD});
        check("model_t3_eol", exp_q[N-1], {1'b0, 1'b1, PAD});
        run(1, 1, 0);

        add_frame(0, N + 10, N + 9, 1000);
        add_frame(0, N, N - 1, 2000);
        model();
        check("model_t4_size", exp_q.size(), 2 * N);
        check("model_t4_trunc", exp_q[N-1], {1'b0, 1'b1, DW'(1000 + N - 1)});
        check("model_t4_next", exp_q[N], {1'b1, 1'b0, DW'(2000)});
        run(2, 0, 1);

        add_frame(7, N, N - 1, 3000);
        model();
        check("model_t5_sof", exp_q[0], {1'b1, 1'b0, DW'(3000)});
        run(1, 0, 0);

        add_frame(0, N, N - 1, 4000);
        model();
        send(12);
        rst_n = 1'b0;
        exp_q.delete();
        stim.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tvalid", m_axis_tvalid, 0);
`ifdef FRAME_STATS_EN
        check("post_rst_counts", {frame_count, short_count, long_count}, 0);
`endif
        add_frame(0, N, N - 1, 5000);
        model();
        run(1, 0, 0);
`ifdef FRAME_STATS_EN
        check("frame_count", frame_count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
